// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: grants a core port and a loader/debug port onto one single-port synchronous memory.
// Define PUNC_ARB_RR_EN to alternate between simultaneous requesters; otherwise the core always wins.
module punc_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [DATA_W-1:0] ld_rdata,
   input  logic              ld_halt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
   typedef enum logic {CORE = 1'b0, LD = 1'b1} owner_t;

   state_t            state;
   owner_t            owner;
   owner_t            winner;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              core_elig;
   logic              ld_elig;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
`ifdef PUNC_ARB_RR_EN
   owner_t            rr_ptr;   // requester that wins the next contention
`endif

   assign core_elig = core_req & ~ld_halt;
   assign ld_elig   = ld_req;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      winner = CORE;
      if (core_elig && ld_elig) begin
`ifdef PUNC_ARB_RR_EN
         winner = rr_ptr;
`else
         winner = CORE;
`endif
      end else if (ld_elig) begin
         winner = LD;
      end
      sel_we    = (winner == LD) ? ld_we    : core_we;
      sel_addr  = (winner == LD) ? ld_addr  : core_addr;
      sel_wdata = (winner == LD) ? ld_wdata : core_wdata;
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= CORE;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         core_ack  <= 1'b0;
         ld_ack    <= 1'b0;
`ifdef PUNC_ARB_RR_EN
         rr_ptr    <= CORE;
`endif
      end else begin
         core_ack <= 1'b0;
         ld_ack   <= 1'b0;
         case (state)
            IDLE: begin
               if (core_elig || ld_elig) begin
                  owner     <= winner;
                  lat_we    <= sel_we;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
                  mem_en    <= 1'b1;
                  mem_we    <= sel_we;
`ifdef PUNC_ARB_RR_EN
                  rr_ptr    <= (winner == CORE) ? LD : CORE;
`endif
                  state     <= ACC;
               end
            end
            ACC: begin
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               core_ack <= (owner == CORE);
               ld_ack   <= (owner == LD);
               state    <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Read data arrives from the memory during RESP, so it is steered rather than re-registered.
   assign mem_addr   = lat_addr;
   assign mem_wdata  = lat_wdata;
   assign core_rdata = (core_ack && !lat_we) ? mem_rdata : '0;
   assign ld_rdata   = (ld_ack && !lat_we) ? mem_rdata : '0;
   assign core_stall = core_req & ~core_ack;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant choice, 3-cycle access slots, shadow memory).
module tb_punc_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_req, core_we, core_ack, core_stall;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          ld_req, ld_we, ld_ack, ld_halt;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_wdata, ld_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] ram     [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   txn_t core_q[$];
   txn_t ld_q[$];
   bit   grants[$];      // 0 = core, 1 = loader, in grant order
   bit   last_owner;     // model: owner of the most recent grant

   punc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata), .core_stall(core_stall),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_ack(ld_ack), .ld_rdata(ld_rdata), .ld_halt(ld_halt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
      return ram.exists(a) ? ram[a] : (a ^ 16'h5a5a);
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5a5a);
   endfunction

   // Synchronous single-port memory the arbiter drives.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else        mem_rdata <= ram_rd(mem_addr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present();
      if (core_q.size() > 0) begin
         core_req = 1'b1; core_we = core_q[0].we; core_addr = core_q[0].addr; core_wdata = core_q[0].wdata;
      end else begin
         core_req = 1'b0;
      end
      if (ld_q.size() > 0) begin
         ld_req = 1'b1; ld_we = ld_q[0].we; ld_addr = ld_q[0].addr; ld_wdata = ld_q[0].wdata;
      end else begin
         ld_req = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_owner = 1'b1;   // after reset the core has priority
   endtask

   // Drives the queued transactions and checks every cycle against the transaction-level model.
   task automatic run_engine(input int max_cycles, input bit rand_halt);
      int   since_grant = 99;
      bit   pend_owner  = 1'b0;
      txn_t pend_t;
      int   cyc = 0;
      pend_t.we = 1'b0; pend_t.addr = '0; pend_t.wdata = '0;
      present();
      while (cyc < max_cycles && (core_q.size() > 0 || ld_q.size() > 0 || since_grant < 2)) begin
         bit ce, le, g, w, exp_en, exp_cack, exp_lack;
         logic [DW-1:0] exp_rd;
         ce = core_req && !ld_halt;
         le = ld_req;
         g  = (since_grant >= 3) && (ce || le);
         w  = le;
         if (ce && le) begin
`ifdef PUNC_ARB_RR_EN
            w = !last_owner;
`else
            w = 1'b0;
`endif
         end
         if (g) begin
            pend_owner = w;
            pend_t     = w ? ld_q[0] : core_q[0];
            grants.push_back(w);
            last_owner = w;
         end
         tick();
         cyc++;
         since_grant = g ? 1 : since_grant + 1;
         exp_en   = (since_grant == 1);
         exp_cack = (since_grant == 2) && !pend_owner;
         exp_lack = (since_grant == 2) && pend_owner;
         exp_rd   = pend_t.we ? '0 : ref_rd(pend_t.addr);
         n_checks++;
         if (mem_en !== exp_en) begin n_fail++; $display("FAIL eng_mem_en cyc %0d: got %b want %b", cyc, mem_en, exp_en); end
         if (exp_en) begin
            n_checks++;
            if (mem_we !== pend_t.we || mem_addr !== pend_t.addr || (pend_t.we && mem_wdata !== pend_t.wdata)) begin
               n_fail++;
               $display("FAIL eng_mem_cmd cyc %0d: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                        cyc, mem_we, mem_addr, mem_wdata, pend_t.we, pend_t.addr, pend_t.wdata);
            end
         end
         n_checks++;
         if (core_ack !== exp_cack || ld_ack !== exp_lack) begin
            n_fail++; $display("FAIL eng_ack cyc %0d: got c=%b l=%b want c=%b l=%b", cyc, core_ack, ld_ack, exp_cack, exp_lack);
         end
         if (exp_cack) begin
            n_checks++;
            if (core_rdata !== exp_rd) begin n_fail++; $display("FAIL eng_core_rdata: got %h want %h", core_rdata, exp_rd); end
         end
         if (exp_lack) begin
            n_checks++;
            if (ld_rdata !== exp_rd) begin n_fail++; $display("FAIL eng_ld_rdata: got %h want %h", ld_rdata, exp_rd); end
         end
         n_checks++;
         if (core_stall !== (core_req && !exp_cack)) begin
            n_fail++; $display("FAIL eng_stall cyc %0d: got %b want %b", cyc, core_stall, core_req && !exp_cack);
         end
         if (since_grant == 2) begin
            if (pend_t.we) ref_mem[pend_t.addr] = pend_t.wdata;
            if (pend_owner) void'(ld_q.pop_front());
            else            void'(core_q.pop_front());
            present();
         end
         if (rand_halt) ld_halt = ($urandom_range(0, 3) == 0);
      end
      ld_halt = 1'b0;
      n_checks++;
      if (core_q.size() != 0 || ld_q.size() != 0) begin
         n_fail++; $display("FAIL eng_timeout: %0d core / %0d loader requests left, want 0", core_q.size(), ld_q.size());
      end
      core_q.delete(); ld_q.delete();
      present();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      core_req = 1'b1; core_we = 1'b0; core_addr = 16'h1111; core_wdata = '0;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h2222; ld_wdata = 16'h3333; ld_halt = 1'b0;
      repeat (3) tick();
      n_checks++;
      if ({mem_en, mem_we, core_ack, ld_ack} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
          core_rdata !== '0 || ld_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got en=%b we=%b ca=%b la=%b a=%h d=%h cr=%h lr=%h want all 0",
                  mem_en, mem_we, core_ack, ld_ack, mem_addr, mem_wdata, core_rdata, ld_rdata);
      end
      core_req = 1'b0; ld_req = 1'b0;
      rst = 1'b0;
      last_owner = 1'b1;
      tick();
      n_checks++;
      if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got mem_en %b want 0", mem_en); end
   endtask

   task automatic test_core_read();
      ram[16'h3000] = 16'h1234; ref_mem[16'h3000] = 16'h1234;
      core_req = 1'b1; core_we = 1'b0; core_addr = 16'h3000; core_wdata = 16'hffff;
      tick();
      last_owner = 1'b0;
      n_checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h3000) begin
         n_fail++; $display("FAIL core_rd_acc: got en=%b we=%b a=%h want 1 0 3000", mem_en, mem_we, mem_addr);
      end
      n_checks++;
      if (core_ack !== 1'b0 || core_stall !== 1'b1) begin
         n_fail++; $display("FAIL core_rd_acc_ack: got ack=%b stall=%b want 0 1", core_ack, core_stall);
      end
      core_addr = 16'h0bad;  // late field change and halt must not disturb the access in flight
      ld_halt = 1'b1;
      tick();
      n_checks++;
      if (mem_en !== 1'b0 || core_ack !== 1'b1 || ld_ack !== 1'b0 || core_rdata !== 16'h1234) begin
         n_fail++; $display("FAIL core_rd_resp: got en=%b ca=%b la=%b rd=%h want 0 1 0 1234", mem_en, core_ack, ld_ack, core_rdata);
      end
      n_checks++;
      if (core_stall !== 1'b0) begin n_fail++; $display("FAIL core_rd_stall_ack: got %b want 0", core_stall); end
      core_req = 1'b0; ld_halt = 1'b0;
      tick();
      n_checks++;
      if (core_ack !== 1'b0 || core_rdata !== '0) begin
         n_fail++; $display("FAIL core_rd_pulse: got ack=%b rd=%h want 0 0", core_ack, core_rdata);
      end
   endtask

   task automatic test_ld_write();
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0200; ld_wdata = 16'hbeef;
      tick();
      last_owner = 1'b1;
      n_checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 16'hbeef) begin
         n_fail++; $display("FAIL ld_wr_acc: got en=%b we=%b a=%h d=%h want 1 1 0200 beef", mem_en, mem_we, mem_addr, mem_wdata);
      end
      tick();
      n_checks++;
      if (ld_ack !== 1'b1 || core_ack !== 1'b0 || ld_rdata !== '0 || mem_we !== 1'b0) begin
         n_fail++; $display("FAIL ld_wr_resp: got la=%b ca=%b lr=%h we=%b want 1 0 0000 0", ld_ack, core_ack, ld_rdata, mem_we);
      end
      ref_mem[16'h0200] = 16'hbeef;
      ld_req = 1'b0;
      tick();
      ld_req = 1'b1; ld_we = 1'b0; ld_wdata = 16'h0000;
      tick();
      tick();
      n_checks++;
      if (ld_ack !== 1'b1 || ld_rdata !== 16'hbeef) begin
         n_fail++; $display("FAIL ld_readback: got ack=%b rd=%h want 1 beef", ld_ack, ld_rdata);
      end
      ld_req = 1'b0;
      tick();
   endtask

   task automatic test_halt();
      int  waited = 0;
      bit  got = 1'b0;
      bit  bad = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0044; ld_halt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (core_ack !== 1'b0 || core_stall !== 1'b1 || mem_en !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL halt_block: got a core grant while halted, want none"); end
      ld_halt = 1'b0;
      while (!got && waited < 4) begin
         tick();
         waited++;
         got = (core_ack === 1'b1);
      end
      last_owner = 1'b0;
      n_checks++;
      if (!got || waited > 3) begin n_fail++; $display("FAIL halt_release: ack after %0d cycles (seen=%b) want <=3", waited, got); end
      n_checks++;
      if (core_rdata !== ref_rd(16'h0044)) begin n_fail++; $display("FAIL halt_rdata: got %h want %h", core_rdata, ref_rd(16'h0044)); end
      core_req = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      txn_t t;
      bit   exp_g[4];
`ifdef PUNC_ARB_RR_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
      pulse_reset();
      grants.delete();
      for (int i = 0; i < 2; i++) begin
         t.we = 1'b0; t.addr = 16'h0010 + 16'(i); t.wdata = '0;        core_q.push_back(t);
         t.we = 1'b1; t.addr = 16'h0020 + 16'(i); t.wdata = 16'(i + 7); ld_q.push_back(t);
      end
      run_engine(60, 1'b0);
      n_checks++;
      if (grants.size() != 4) begin
         n_fail++; $display("FAIL contention_count: got %0d grants want 4", grants.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (grants[i] !== exp_g[i]) begin n_fail++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, grants[i], exp_g[i]); end
         end
      end
   endtask

   task automatic test_random();
      txn_t t;
      for (int i = 0; i < 15; i++) begin
         t.we = 1'($urandom_range(0, 1)); t.addr = 16'h0100 + 16'($urandom_range(0, 7)); t.wdata = 16'($urandom);
         core_q.push_back(t);
         t.we = 1'($urandom_range(0, 1)); t.addr = 16'h0100 + 16'($urandom_range(0, 7)); t.wdata = 16'($urandom);
         ld_q.push_back(t);
      end
      run_engine(3000, 1'b1);
   endtask

   task automatic test_abort();
      txn_t t;
      bit   bad = 1'b0;
      core_req = 1'b1; core_we = 1'b0; core_addr = 16'h3000; core_wdata = '0;
      tick();
      n_checks++;
      if (mem_en !== 1'b1) begin n_fail++; $display("FAIL abort_setup: got mem_en %b want 1", mem_en); end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mem_en, mem_we, core_ack, ld_ack} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
          core_rdata !== '0 || ld_rdata !== '0) begin
         n_fail++; $display("FAIL abort_outputs: got en=%b ca=%b a=%h want 0 0 0000", mem_en, core_ack, mem_addr);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         if (core_ack !== 1'b0 || mem_en !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin n_fail++; $display("FAIL abort_no_ack: got ack or mem_en during reset, want none"); end
      rst = 1'b0;
      last_owner = 1'b1;
      grants.delete();
      t.we = 1'b0; t.addr = 16'h3000; t.wdata = '0;
      core_q.push_back(t);
      run_engine(20, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_core_read();
      test_ld_write();
      test_halt();
      test_contention();
      test_random();
      test_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
